// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: pc4 + word offset, wrapping modulo 2^32.
module branch_target_calc (
  input  logic [31:0] pc4,
  input  logic [31:0] imm,
  output logic [31:0] target
);

  assign target = pc4 + (imm << 2);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, IF/ID register with a
// one-entry skid buffer, and branch redirect that drains an in-flight access.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_pc4,
  input  logic [31:0]  branch_imm,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  if_id_instr,
  output logic [31:0]  if_id_pc4,
  output logic         if_id_valid,
  output logic [15:0]  if_id_imm16,
  output fetch_state_t dbg_state
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  redirect_q;
  logic         busy;
  if_id_t       if_id_q;
  if_id_t       skid_q;
  logic         if_id_valid_q;

  logic [31:0]  target;
  logic [31:0]  target_aligned;
  logic [31:0]  pc_plus4;
  logic         done;
  logic         in_flight;

  branch_target_calc u_branch_target_calc (
    .pc4    (branch_pc4),
    .imm    (branch_imm),
    .target (target)
  );

  assign target_aligned = target & ALIGN_MASK;
  assign pc_plus4       = pc_q + 32'd4;

  // Handshake: an access completes on any cycle with imem_req && imem_ready;
  // once imem_req is high it and imem_addr stay put until that cycle.
  always_comb begin
    imem_req = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH:   imem_req = !stall || busy;
        DRAIN:   imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign done      = imem_req && imem_ready;
  assign in_flight = imem_req && !imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      pc_q          <= RESET_PC & ALIGN_MASK;
      redirect_q    <= RESET_PC & ALIGN_MASK;
      busy          <= 1'b0;
      if_id_q       <= '{instr: NOP_INSTR, pc4: 32'd0};
      skid_q        <= '{instr: NOP_INSTR, pc4: 32'd0};
      if_id_valid_q <= 1'b0;
    end else begin
      busy <= in_flight;
      case (state)
        FETCH: begin
          if (branch_taken) begin
            if_id_valid_q <= 1'b0;
            // An access already raised must finish on its old address first.
            if (in_flight) begin
              redirect_q <= target_aligned;
              state      <= DRAIN;
            end else begin
              pc_q <= target_aligned;
            end
          end else if (done) begin
            pc_q <= pc_plus4;
            if (stall) begin
              skid_q <= '{instr: imem_rdata, pc4: pc_plus4};
              state  <= FULL;
            end else begin
              if_id_q       <= '{instr: imem_rdata, pc4: pc_plus4};
              if_id_valid_q <= 1'b1;
            end
          end else if (!stall) begin
            if_id_valid_q <= 1'b0;
          end
        end

        DRAIN: begin
          if_id_valid_q <= 1'b0;
          if (done) begin
            pc_q  <= branch_taken ? target_aligned : redirect_q;
            state <= FETCH;
          end else if (branch_taken) begin
            redirect_q <= target_aligned;
          end
        end

        FULL: begin
          if (branch_taken) begin
            pc_q          <= target_aligned;
            if_id_valid_q <= 1'b0;
            state         <= FETCH;
          end else if (!stall) begin
            if_id_q       <= skid_q;
            if_id_valid_q <= 1'b1;
            state         <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_valid_q;
  assign if_id_imm16 = if_id_q.instr[15:0];
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait/wait-state memory, stall skid,
// branch flush/wrap, drain on redirect and mid-access reset.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  branch_pc4 = 32'd0;
  logic [31:0]  branch_imm = 32'd0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ready = 1'b0;
  logic [31:0]  imem_rdata;
  logic [31:0]  if_id_instr;
  logic [31:0]  if_id_pc4;
  logic         if_id_valid;
  logic [15:0]  if_id_imm16;
  fetch_state_t dbg_state;

  int total  = 0;
  int passed = 0;

  logic [63:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc4   = 32'd0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc4   (branch_pc4),
    .branch_imm   (branch_imm),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .if_id_imm16  (if_id_imm16),
    .dbg_state    (dbg_state)
  );

  // Memory model: each word returns its own address tagged with 0xA000.
  assign imem_rdata = imem_addr | 32'h0000_A000;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  // Called one time unit after a rising edge; checks request outputs mid-cycle
  // and the IF/ID valid bit just after the next edge (exp_v < 0 skips it).
  task automatic step(input logic st, input logic br, input logic [31:0] bp4,
                      input logic [31:0] bim, input logic rdy, input logic exp_req,
                      input logic [31:0] exp_addr, input int exp_v);
    stall        = st;
    branch_taken = br;
    branch_pc4   = bp4;
    branch_imm   = bim;
    imem_ready   = rdy;
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    #1;
    if (exp_v >= 0) chk("if_id_valid", 32'(if_id_valid), 32'(exp_v));
  endtask

  // Scoreboard: every newly presented IF/ID instruction must match the queue head.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && if_id_valid && (!prev_valid || if_id_pc4 !== prev_pc4)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_instr", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", if_id_instr, e[63:32]);
        chk("sb_pc4", if_id_pc4, e[31:0]);
        chk("sb_imm16", 32'(if_id_imm16), 32'(e[47:32]));
      end
    end
    prev_valid = if_id_valid;
    prev_pc4   = if_id_pc4;
  end

  initial begin
    // Reset values while rst_n is low
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait streaming, then three wait states at address 8
    push(32'h0000_A000, 32'h4);
    step(0, 0, 0, 0, 1, 1, 32'h0, 1);
    push(32'h0000_A004, 32'h8);
    step(0, 0, 0, 0, 1, 1, 32'h4, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 32'h8, 0);
    push(32'h0000_A008, 32'hC);
    step(0, 0, 0, 0, 1, 1, 32'h8, 1);
    push(32'h0000_A00C, 32'h10);
    step(0, 0, 0, 0, 1, 1, 32'hC, 1);

    // Stall arriving while 0x10 is pending: completion parks in the skid buffer
    step(0, 0, 0, 0, 0, 1, 32'h10, 0);
    step(1, 0, 0, 0, 1, 1, 32'h10, 0);
    chk("full_state", 32'(dbg_state), 32'(FULL));
    chk("full_hold_instr", if_id_instr, 32'h0000_A00C);
    chk("full_hold_pc4", if_id_pc4, 32'h10);
    step(1, 0, 0, 0, 1, 0, 32'h14, 0);
    chk("full_state2", 32'(dbg_state), 32'(FULL));
    push(32'h0000_A010, 32'h14);
    step(0, 0, 0, 0, 1, 0, 32'h14, 1);
    chk("unfull_state", 32'(dbg_state), 32'(FETCH));
    push(32'h0000_A014, 32'h18);
    step(0, 0, 0, 0, 1, 1, 32'h14, 1);

    // Backward branch, then a target that wraps past 2^32
    step(0, 1, 32'h10, 32'hFFFF_FFFE, 1, 1, 32'h18, 0);
    push(32'h0000_A008, 32'hC);
    step(0, 0, 0, 0, 1, 1, 32'h8, 1);
    step(0, 1, 32'hFFFF_FFFC, 32'h3, 1, 1, 32'hC, 0);
    push(32'h0000_A008, 32'hC);
    step(0, 0, 0, 0, 1, 1, 32'h8, 1);

    // Redirect to 0x20, then branch while 0x20 is held in wait states
    step(0, 1, 32'h20, 32'h0, 1, 1, 32'hC, 0);
    step(0, 0, 0, 0, 0, 1, 32'h20, 0);
    step(0, 1, 32'h40, 32'h4, 0, 1, 32'h20, 0);
    chk("drain_state", 32'(dbg_state), 32'(DRAIN));
    step(0, 1, 32'h60, 32'h0, 0, 1, 32'h20, 0);
    chk("drain_state2", 32'(dbg_state), 32'(DRAIN));
    step(1, 0, 0, 0, 1, 1, 32'h20, 0);
    chk("drain_exit_state", 32'(dbg_state), 32'(FETCH));
    push(32'h0000_A060, 32'h64);
    step(0, 0, 0, 0, 1, 1, 32'h60, 1);

    // Reach FULL, then pulse reset mid-cycle with stall and ready still high
    step(0, 0, 0, 0, 0, 1, 32'h64, 0);
    step(1, 0, 0, 0, 1, 1, 32'h64, 0);
    chk("pre_rst_state", 32'(dbg_state), 32'(FULL));
    stall      = 1'b1;
    imem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", 32'(if_id_valid), 32'd0);
    chk("mid_rst_instr", if_id_instr, 32'h0);
    chk("mid_rst_pc4", if_id_pc4, 32'h0);
    chk("mid_rst_state", 32'(dbg_state), 32'(FETCH));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(32'h0000_A000, 32'h4);
    step(0, 0, 0, 0, 1, 1, 32'h0, 1);
    push(32'h0000_A004, 32'h8);
    step(0, 0, 0, 0, 1, 1, 32'h4, 1);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS datapath. It holds the PC and issues word fetches to instruction memory over a req/ready handshake. It redirects on taken branches using the sign-extended offset computed in ID. It loads the IF/ID pipeline register, whose instruction bits [15:0] feed the decode-stage sign extender.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  pipeline clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
stall  in  1  hazard-unit request to hold IF/ID and stop new fetches
branch_taken  in  1  ID-stage taken branch: redirect the PC and flush IF/ID
branch_pc4  in  32  PC+4 of the branch instruction (from IF/ID)
branch_imm  in  32  sign-extended branch offset, in words
imem_req  out  1  instruction-memory request
imem_addr  out  32  word-aligned fetch address
imem_ready  in  1  access completes this cycle when imem_req && imem_ready
imem_rdata  in  32  instruction word, valid on completion
if_id_instr  out  32  IF/ID instruction
if_id_pc4  out  32  IF/ID PC+4
if_id_valid  out  1  IF/ID holds a real instruction
if_id_imm16  out  16  if_id_instr[15:0], wired directly to the sign extender

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=FETCH, busy=0.
  - if_id_instr=0, if_id_pc4=0, if_id_valid=0, imem_req=0 while rst_n is low.
  - The first request is issued in the first cycle after rst_n deasserts.
- Reset asserted mid-access aborts everything immediately. Late imem_ready is ignored because imem_req is 0.
- imem_addr = pc always. pc[1:0] is always 00.
- busy = 1 when imem_req was high in the previous cycle and imem_ready was low.
- Handshake rule: once imem_req rises, imem_req and imem_addr hold stable until the completing cycle.
- Branch target = branch_pc4 + (branch_imm << 2), modulo 2^32. Wrap-around is silent.
- Priority when inputs coincide: branch_taken > stall > normal advance.
- States: FETCH, DRAIN, FULL.
- FETCH:
  - imem_req = !stall || busy.
  - Completion with no branch and no stall: IF/ID <= {imem_rdata, pc+4}, if_id_valid <= 1, pc <= pc+4. Back-to-back completions give 1 instruction per cycle.
  - Completion with stall=1: IF/ID holds. Skid buffer <= {imem_rdata, pc+4}; pc <= pc+4; go to FULL.
  - branch_taken and the access completes (or no access is in flight): drop the data, pc <= target, if_id_valid <= 0, stay in FETCH.
  - branch_taken while busy and not completing: redirect_q <= target, if_id_valid <= 0, go to DRAIN.
  - No completion and no branch: if stall=0, if_id_valid <= 0 (bubble); if stall=1, IF/ID holds.
- DRAIN:
  - imem_req = 1 on the old address.
  - On completion: discard the data, pc <= redirect_q, go to FETCH.
  - A further branch_taken in DRAIN overwrites redirect_q (last one wins).
  - IF/ID: valid is forced to 0 while in DRAIN, regardless of stall.
- FULL:
  - imem_req = 0.
  - stall=0: IF/ID <= skid, valid <= 1, go to FETCH. The next request issues the following cycle.
  - branch_taken: drop the skid, pc <= target, if_id_valid <= 0, go to FETCH.
- Flush latency: the IF/ID register shows valid=0 on the edge after branch_taken. The first target instruction appears at least 2 cycles later with zero-wait memory.
- A flushed IF/ID keeps its instr/pc4 contents; only valid is cleared.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (FETCH=2'd0, DRAIN=2'd1, FULL=2'd2)
  - NOP_INSTR=32'h0000_0000
  - default RESET_PC
- Sub-module branch_target_calc: combinational 32-bit pc4 + (imm<<2). It is reused by the ID-stage branch compare logic.
- The skid buffer and FSM stay inline.

Test Plan:
1. Reset, then zero-wait imem returning addr|0xA000 -> imem_addr sequence 0,4,8,C. if_id_instr = A000, A004, … with valid=1 each cycle. if_id_pc4 = 4, 8, C.
2. imem_ready low for 3 cycles at addr 8 -> imem_req and imem_addr=8 stable for 4 cycles. if_id_valid=0 bubbles, then instr A008 appears.
3. stall=1 for 2 cycles as addr 8 completes -> IF/ID holds A004, state FULL, imem_req=0. On stall release: A008 is loaded, then a fetch at C.
4. branch_taken with branch_pc4=0x10, branch_imm=0xFFFF_FFFE -> next fetch at 0x08. IF/ID valid=0 for one cycle. Also branch_imm=0x0000_0003 from pc4=0xFFFF_FFFC -> target 0x0000_0008 (wrap).
5. branch_taken while addr 0x20 is stalled 2 cycles in imem -> DRAIN, imem_addr stays 0x20. Its data is discarded and never reaches IF/ID; the next fetch is at the target.
6. rst_n pulsed low mid-access with stall=1 and FULL -> outputs go to reset values immediately. The first post-reset imem_addr is RESET_PC.
